// File: rtl/morse_pkg.sv
// Types and constants shared by the Morse keyer and the decoder path.
package morse_pkg;

  localparam logic [1:0] GAP  = 2'b00;
  localparam logic [1:0] DOT  = 2'b01;
  localparam logic [1:0] DASH = 2'b10;
  localparam logic [1:0] STOP = 2'b11;

  localparam int unsigned NUM_LETTERS = 26;
  localparam int unsigned NUM_CHARS   = 36;
  localparam int unsigned CODE_SPACE  = 36;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMark,
    StSpace,
    StCharGap,
    StWordGap
  } state_e;

  // pat is MSB-first and left-aligned; a 1 bit is a dash.
  typedef struct packed {
    logic       supported;
    logic [2:0] len;
    logic [4:0] pat;
  } rom_entry_t;

  function automatic rom_entry_t mk_entry(input logic [2:0] len, input logic [4:0] pat);
    rom_entry_t e;
    e.supported = 1'b1;
    e.len       = len;
    e.pat       = pat;
    return e;
  endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Character handshake and key/symbol outputs of the Morse keyer.
interface morse_keyer_if;
  logic [5:0] char_code;
  logic       char_valid;
  logic       char_ready;
  logic       cancel;
  logic       key_out;
  logic [1:0] sym_type;
  logic       done;
  logic       err;

  modport master (
    output char_code, char_valid, cancel,
    input  char_ready, key_out, sym_type, done, err
  );

  modport slave (
    input  char_code, char_valid, cancel,
    output char_ready, key_out, sym_type, done, err
  );
endinterface

// File: rtl/morse_rom.sv
// Character code to Morse pattern table (A-Z, 0-9; code 36 only with MORSE_WORD_GAP_EN).
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code_i,
  output rom_entry_t entry_o
);

  always_comb begin
    entry_o = '0;
    case (char_code_i)
      6'd0:  entry_o = mk_entry(3'd2, 5'b01000);  // A .-
      6'd1:  entry_o = mk_entry(3'd4, 5'b10000);  // B -...
      6'd2:  entry_o = mk_entry(3'd4, 5'b10100);  // C -.-.
      6'd3:  entry_o = mk_entry(3'd3, 5'b10000);  // D -..
      6'd4:  entry_o = mk_entry(3'd1, 5'b00000);  // E .
      6'd5:  entry_o = mk_entry(3'd4, 5'b00100);  // F ..-.
      6'd6:  entry_o = mk_entry(3'd3, 5'b11000);  // G --.
      6'd7:  entry_o = mk_entry(3'd4, 5'b00000);  // H ....
      6'd8:  entry_o = mk_entry(3'd2, 5'b00000);  // I ..
      6'd9:  entry_o = mk_entry(3'd4, 5'b01110);  // J .---
      6'd10: entry_o = mk_entry(3'd3, 5'b10100);  // K -.-
      6'd11: entry_o = mk_entry(3'd4, 5'b01000);  // L .-..
      6'd12: entry_o = mk_entry(3'd2, 5'b11000);  // M --
      6'd13: entry_o = mk_entry(3'd2, 5'b10000);  // N -.
      6'd14: entry_o = mk_entry(3'd3, 5'b11100);  // O ---
      6'd15: entry_o = mk_entry(3'd4, 5'b01100);  // P .--.
      6'd16: entry_o = mk_entry(3'd4, 5'b11010);  // Q --.-
      6'd17: entry_o = mk_entry(3'd3, 5'b01000);  // R .-.
      6'd18: entry_o = mk_entry(3'd3, 5'b00000);  // S ...
      6'd19: entry_o = mk_entry(3'd1, 5'b10000);  // T -
      6'd20: entry_o = mk_entry(3'd3, 5'b00100);  // U ..-
      6'd21: entry_o = mk_entry(3'd4, 5'b00010);  // V ...-
      6'd22: entry_o = mk_entry(3'd3, 5'b01100);  // W .--
      6'd23: entry_o = mk_entry(3'd4, 5'b10010);  // X -..-
      6'd24: entry_o = mk_entry(3'd4, 5'b10110);  // Y -.--
      6'd25: entry_o = mk_entry(3'd4, 5'b11000);  // Z --..
      6'd26: entry_o = mk_entry(3'd5, 5'b11111);  // 0
      6'd27: entry_o = mk_entry(3'd5, 5'b01111);  // 1
      6'd28: entry_o = mk_entry(3'd5, 5'b00111);  // 2
      6'd29: entry_o = mk_entry(3'd5, 5'b00011);  // 3
      6'd30: entry_o = mk_entry(3'd5, 5'b00001);  // 4
      6'd31: entry_o = mk_entry(3'd5, 5'b00000);  // 5
      6'd32: entry_o = mk_entry(3'd5, 5'b10000);  // 6
      6'd33: entry_o = mk_entry(3'd5, 5'b11000);  // 7
      6'd34: entry_o = mk_entry(3'd5, 5'b11100);  // 8
      6'd35: entry_o = mk_entry(3'd5, 5'b11110);  // 9
`ifdef MORSE_WORD_GAP_EN
      6'd36: entry_o = mk_entry(3'd0, 5'b00000);  // word space: no marks
`endif
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: one character per handshake, timed key output and symbol type.
// Define MORSE_WORD_GAP_EN to accept code 36 as a 7-unit word space.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 20
) (
  input  logic          clock100Hz,
  input  logic          clear,
  morse_keyer_if.slave  bus
);

`ifdef MORSE_WORD_GAP_EN
  localparam int unsigned MaxCount = 7 * UNIT_TICKS;
`else
  localparam int unsigned MaxCount = 3 * UNIT_TICKS;
`endif
  localparam int unsigned CntW = $clog2(MaxCount + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntUnit = CntW'(UNIT_TICKS);
  localparam logic [CntW-1:0] CntDash = CntW'(3 * UNIT_TICKS);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [CntW-1:0] CntWord = CntW'(7 * UNIT_TICKS);
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d, idx_nxt;
  logic [2:0]      len_q, len_d;
  logic [4:0]      pat_q, pat_d, nxt_sh, sym_sh;
  logic            key_q, key_d;
  logic [1:0]      type_q, type_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            transfer;
  rom_entry_t      rom;

  morse_rom u_rom (
    .char_code_i (bus.char_code),
    .entry_o     (rom)
  );

  assign transfer = bus.char_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    err_d   = 1'b0;
    idx_nxt = idx_q + 3'd1;
    nxt_sh  = pat_q << idx_nxt;

    case (state_q)
      StIdle: begin
        // Table lookup is captured on the transfer edge so char_code is free afterwards.
        if (transfer) begin
          state_d = StLoad;
          len_d   = rom.len;
          pat_d   = rom.pat;
          err_d   = !rom.supported;
        end
      end
      StLoad: begin
        if (err_q) begin
          state_d = StIdle;
        end
`ifdef MORSE_WORD_GAP_EN
        else if (len_q == 3'd0) begin
          state_d = StWordGap;
          cnt_d   = CntWord;
        end
`endif
        else begin
          state_d = StMark;
          idx_d   = '0;
          cnt_d   = pat_q[4] ? CntDash : CntUnit;
        end
      end
      StMark: begin
        if (cnt_q == CntOne) begin
          if (idx_nxt < len_q) begin
            state_d = StSpace;
            cnt_d   = CntUnit;
          end else begin
            state_d = StCharGap;
            cnt_d   = CntDash;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSpace: begin
        if (cnt_q == CntOne) begin
          state_d = StMark;
          idx_d   = idx_nxt;
          cnt_d   = nxt_sh[4] ? CntDash : CntUnit;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StCharGap, StWordGap: begin
        if (cnt_q == CntOne) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.cancel && (state_q != StIdle)) begin
      state_d = StIdle;
    end

    // Outputs are derived from the next state so they are registered with it.
    sym_sh  = pat_d << idx_d;
    key_d   = (state_d == StMark);
    ready_d = (state_d == StIdle);
    done_d  = ((state_d == StCharGap) || (state_d == StWordGap)) && (cnt_d == CntOne);
    case (state_d)
      StMark:                        type_d = sym_sh[4] ? DASH : DOT;
      StSpace, StCharGap, StWordGap: type_d = GAP;
      default:                       type_d = STOP;
    endcase
  end

  always_ff @(posedge clock100Hz or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      key_q   <= 1'b0;
      type_q  <= STOP;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      type_q  <= type_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign bus.char_ready = ready_q;
  assign bus.key_out    = key_q;
  assign bus.sym_type   = type_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
